spi_frame_rx: RTL and testbench

Parametrised SPI peripheral (receive-only) for host-to-FPGA image/command transfer into the BNN OCR datapath. It supports all four SPI modes, a configurable frame width and bit order, and an internal show-ahead FIFO with a ready/valid output. It also detects mid-frame CS loss and SCLK stalls, and reports them as sticky status flags. It replaces the single-byte, mode-0-only receiver with its take/valid handshake.

---
 rtl/spi_pkg.sv | 16 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/spi_frame_rx.sv | 167 ++++++++++++++++
 tb/tb_spi_frame_rx.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI frame receiver.
package spi_pkg;

    typedef enum logic {
        SPI_IDLE,
        SPI_SHIFT
    } spi_state_t;

    localparam int unsigned SPI_TIMEOUT_DEFAULT = 10000;

    // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling edge.
    function automatic logic spi_sample_on_rising(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: pop_data always presents the head word.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO only lands if the head is popped on the same edge.
    always_comb begin
        full     = (count_r == CW'(DEPTH));
        empty    = (count_r == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        count    = count_r;
        pop_data = empty ? '0 : mem[rd_ptr];
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spi_frame_rx.sv
// Receive-only SPI peripheral: synchronises SCLK/COPI/CS, assembles frames
// of FRAME_BITS in any SPI mode and queues them in a show-ahead FIFO.
module spi_frame_rx
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_BITS     = 8,
    parameter bit          CPOL           = 1'b0,
    parameter bit          CPHA           = 1'b0,
    parameter bit          MSB_FIRST      = 1'b1,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = SPI_TIMEOUT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          SCLK,
    input  logic                          COPI,
    input  logic                          spi_cs_n,
    input  logic                          rx_enable,
    output logic [FRAME_BITS-1:0]         rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          timeout,
    output logic                          abort,
    input  logic                          clear_status
);

    localparam int unsigned BCW  = $clog2(FRAME_BITS);
    localparam int unsigned TCW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);
    localparam logic [TCW-1:0] TMO_LIMIT = TCW'(TIMEOUT_CYCLES);
    localparam bit TMO_ON      = (TIMEOUT_CYCLES != 0);
    localparam bit SAMPLE_RISE = spi_sample_on_rising(CPOL, CPHA);

    logic sclk_meta, sclk_s, sclk_d;
    logic copi_meta, copi_s;
    logic cs_meta, cs_sync;

    spi_state_t            state;
    logic [BCW-1:0]        bit_cnt;
    logic [TCW-1:0]        tmo_cnt;
    logic [FRAME_BITS-1:0] shreg;

    logic                  sample_edge;
    logic                  stop;
    logic [FRAME_BITS-1:0] next_word;
    logic                  frame_done;
    logic                  abort_set;
    logic                  timeout_set;
    logic                  overflow_set;

    logic                  fifo_full;
    logic                  fifo_empty;

    // Two-flop synchronisers plus a third SCLK stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_meta <= CPOL;
            sclk_s    <= CPOL;
            sclk_d    <= CPOL;
            copi_meta <= 1'b0;
            copi_s    <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
        end else begin
            sclk_meta <= SCLK;
            sclk_s    <= sclk_meta;
            sclk_d    <= sclk_s;
            copi_meta <= COPI;
            copi_s    <= copi_meta;
            cs_meta   <= spi_cs_n;
            cs_sync   <= cs_meta;
        end
    end

    // Edge/event decode; CS loss or disable takes priority over a coincident sample edge.
    always_comb begin
        sample_edge  = SAMPLE_RISE ? (sclk_s && !sclk_d) : (!sclk_s && sclk_d);
        stop         = cs_sync || !rx_enable;
        next_word    = MSB_FIRST ? {shreg[FRAME_BITS-2:0], copi_s}
                                 : {copi_s, shreg[FRAME_BITS-1:1]};
        frame_done   = (state == SPI_SHIFT) && !stop && sample_edge && (bit_cnt == LAST_BIT);
        abort_set    = (state == SPI_SHIFT) && stop && (bit_cnt != '0);
        timeout_set  = TMO_ON && (state == SPI_SHIFT) && !stop && !sample_edge &&
                       (bit_cnt != '0) && (tmo_cnt == TMO_LIMIT);
        overflow_set = frame_done && fifo_full && !rx_ready;
    end

    // Frame assembly FSM with bit counter and stall timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SPI_IDLE;
            bit_cnt <= '0;
            tmo_cnt <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                SPI_IDLE: begin
                    busy <= 1'b0;
                    if (!cs_sync && rx_enable) begin
                        state   <= SPI_SHIFT;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                    end
                end
                SPI_SHIFT: begin
                    if (stop) begin
                        state   <= SPI_IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                    end else if (sample_edge) begin
                        shreg   <= next_word;
                        tmo_cnt <= '0;
                        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BCW'(1);
                    end else if (timeout_set) begin
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                    end else if (TMO_ON && (bit_cnt != '0)) begin
                        tmo_cnt <= tmo_cnt + TCW'(1);
                    end else begin
                        tmo_cnt <= '0;
                    end
                end
                default: begin
                    state <= SPI_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky status flags; a set event in the same cycle beats clear_status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            timeout  <= 1'b0;
            abort    <= 1'b0;
        end else begin
            overflow <= overflow_set || (overflow && !clear_status);
            timeout  <= timeout_set  || (timeout  && !clear_status);
            abort    <= abort_set    || (abort    && !clear_status);
        end
    end

    sync_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (frame_done),
        .push_data (next_word),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed/random bench for spi_frame_rx: three instances cover modes 0, 3 and 1.
module tb_spi_frame_rx;

    localparam int HALF = 40;   // SCLK half period = 4 clk cycles
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    logic sclk_v [3];
    logic copi_v [3];
    logic csn_v  [3];
    logic en_v   [3];
    logic rdy_v  [3];
    logic clr_v  [3];
    logic val_v  [3];
    logic busy_v [3];
    logic ovf_v  [3];
    logic tmo_v  [3];
    logic abt_v  [3];
    logic [2:0]  cnt_v [3];
    logic [7:0]  d0;
    logic [15:0] d1;
    logic [7:0]  d2;

    int fb_t   [3] = '{8, 16, 8};
    int msb_t  [3] = '{1, 0, 1};
    int cpol_t [3] = '{0, 1, 0};
    int cpha_t [3] = '{0, 1, 1};

    int vectors = 0;
    int miscompares = 0;

    // reference model: expected FIFO contents and overflow for the DUT under test
    logic [31:0] exp_q [$];
    bit          m_ovf;

    int          valid_cycles0 = 0;
    logic [31:0] last_head0 = '0;

    spi_frame_rx #(.FRAME_BITS(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
                   .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(50)) dut0 (
        .clk(clk), .rst(rst), .SCLK(sclk_v[0]), .COPI(copi_v[0]), .spi_cs_n(csn_v[0]),
        .rx_enable(en_v[0]), .rx_data(d0), .rx_valid(val_v[0]), .rx_ready(rdy_v[0]),
        .fifo_count(cnt_v[0]), .busy(busy_v[0]), .overflow(ovf_v[0]), .timeout(tmo_v[0]),
        .abort(abt_v[0]), .clear_status(clr_v[0]));

    spi_frame_rx #(.FRAME_BITS(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0),
                   .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .SCLK(sclk_v[1]), .COPI(copi_v[1]), .spi_cs_n(csn_v[1]),
        .rx_enable(en_v[1]), .rx_data(d1), .rx_valid(val_v[1]), .rx_ready(rdy_v[1]),
        .fifo_count(cnt_v[1]), .busy(busy_v[1]), .overflow(ovf_v[1]), .timeout(tmo_v[1]),
        .abort(abt_v[1]), .clear_status(clr_v[1]));

    spi_frame_rx #(.FRAME_BITS(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1),
                   .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(0)) dut2 (
        .clk(clk), .rst(rst), .SCLK(sclk_v[2]), .COPI(copi_v[2]), .spi_cs_n(csn_v[2]),
        .rx_enable(en_v[2]), .rx_data(d2), .rx_valid(val_v[2]), .rx_ready(rdy_v[2]),
        .fifo_count(cnt_v[2]), .busy(busy_v[2]), .overflow(ovf_v[2]), .timeout(tmo_v[2]),
        .abort(abt_v[2]), .clear_status(clr_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observe dut0 handshake: how many cycles rx_valid is high and the word shown
    always @(negedge clk) begin
        if (val_v[0]) begin
            valid_cycles0 = valid_cycles0 + 1;
            last_head0 = {24'b0, d0};
        end
    end

    function automatic logic [31:0] head(input int d);
        case (d)
            0:       return {24'b0, d0};
            1:       return {16'b0, d1};
            default: return {24'b0, d2};
        endcase
    endfunction

    function automatic logic [31:0] flags(input int d);
        return {29'b0, ovf_v[d], tmo_v[d], abt_v[d]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_push(input logic [31:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else m_ovf = 1'b1;
    endtask

    task automatic cs_low(input int d);
        csn_v[d] = 1'b0;
        #(2 * HALF);
    endtask

    task automatic cs_high(input int d);
        #HALF;
        csn_v[d] = 1'b1;
        #(2 * HALF);
    endtask

    // tx[k] is the k-th bit on the wire
    task automatic send_bits(input int d, input int n, input logic [31:0] tx);
        logic idle;
        idle = (cpol_t[d] != 0);
        for (int k = 0; k < n; k++) begin
            if (cpha_t[d] == 0) begin
                copi_v[d] = tx[k];
                #HALF;
                sclk_v[d] = ~idle;
                #HALF;
                sclk_v[d] = idle;
            end else begin
                sclk_v[d] = ~idle;
                copi_v[d] = tx[k];
                #HALF;
                sclk_v[d] = idle;
                #HALF;
            end
        end
    endtask

    task automatic send_word(input int d, input logic [31:0] value);
        logic [31:0] tx;
        tx = '0;
        for (int k = 0; k < fb_t[d]; k++)
            tx[k] = (msb_t[d] != 0) ? value[fb_t[d] - 1 - k] : value[k];
        send_bits(d, fb_t[d], tx);
    endtask

    task automatic pop_one(input int d);
        @(negedge clk) rdy_v[d] = 1'b1;
        @(negedge clk) rdy_v[d] = 1'b0;
    endtask

    task automatic pulse_clear(input int d);
        @(negedge clk) clr_v[d] = 1'b1;
        @(negedge clk) clr_v[d] = 1'b0;
    endtask

    task automatic drain(input int d, input string tag);
        check({tag, "_count"}, {29'b0, cnt_v[d]}, exp_q.size());
        while (exp_q.size() > 0) begin
            check({tag, "_valid"}, {31'b0, val_v[d]}, 32'd1);
            check({tag, "_head"}, head(d), exp_q.pop_front());
            pop_one(d);
        end
        check({tag, "_empty"}, {31'b0, val_v[d]}, 32'd0);
    endtask

    function automatic logic [31:0] rnd(input int d);
        return $urandom & ((32'd1 << fb_t[d]) - 32'd1);
    endfunction

    initial begin
        int vc;
        logic [31:0] w;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sclk_v[i] = (cpol_t[i] != 0);
            copi_v[i] = 1'b0;
            csn_v[i]  = 1'b1;
            en_v[i]   = 1'b1;
            rdy_v[i]  = 1'b0;
            clr_v[i]  = 1'b0;
        end
        exp_q.delete();
        m_ovf = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 3; i++) begin
            check("reset_count", {29'b0, cnt_v[i]}, 32'd0);
            check("reset_valid", {31'b0, val_v[i]}, 32'd0);
            check("reset_data", head(i), 32'd0);
            check("reset_flags", flags(i), 32'd0);
            check("reset_busy", {31'b0, busy_v[i]}, 32'd0);
        end
        rst = 1'b0;
        wait_clk(4);

        // mode 0: single frame with the consumer always ready
        rdy_v[0] = 1'b1;
        vc = valid_cycles0;
        cs_low(0);
        check("m0_busy", {31'b0, busy_v[0]}, 32'd1);
        send_word(0, 32'hA5);
        cs_high(0);
        wait_clk(8);
        check("m0_valid_cycles", valid_cycles0 - vc, 32'd1);
        check("m0_data", last_head0, 32'hA5);
        check("m0_flags", flags(0), 32'd0);
        check("m0_idle_busy", {31'b0, busy_v[0]}, 32'd0);
        rdy_v[0] = 1'b0;

        // mode 0: random frames back-to-back under one CS
        cs_low(0);
        for (int i = 0; i < 3; i++) begin
            w = rnd(0);
            send_word(0, w);
            model_push(w);
        end
        cs_high(0);
        wait_clk(6);
        drain(0, "m0_rand");

        // mode 3, 16-bit LSB first, two frames with CS held low
        cs_low(1);
        send_word(1, 32'h1234);
        model_push(32'h1234);
        send_word(1, 32'hBEEF);
        model_push(32'hBEEF);
        cs_high(1);
        wait_clk(6);
        check("m3_peak_count", {29'b0, cnt_v[1]}, 32'd2);
        drain(1, "m3");
        cs_low(1);
        for (int i = 0; i < 2; i++) begin
            w = rnd(1);
            send_word(1, w);
            model_push(w);
        end
        cs_high(1);
        wait_clk(6);
        drain(1, "m3_rand");
        check("m3_flags", flags(1), 32'd0);

        // mode 3: rx_enable drop mid-frame discards the partial word
        cs_low(1);
        send_bits(1, 5, rnd(1));
        wait_clk(2);
        en_v[1] = 1'b0;
        wait_clk(4);
        check("en_drop_abort", flags(1), 32'd1);
        check("en_drop_count", {29'b0, cnt_v[1]}, 32'd0);
        en_v[1] = 1'b1;
        cs_high(1);
        pulse_clear(1);
        check("en_drop_clear", flags(1), 32'd0);

        // overflow: five frames into a four-entry FIFO
        m_ovf = 1'b0;
        cs_low(0);
        for (int i = 1; i <= 5; i++) begin
            send_word(0, i);
            model_push(i);
        end
        cs_high(0);
        wait_clk(6);
        check("ovf_count", {29'b0, cnt_v[0]}, exp_q.size());
        check("ovf_flag", {31'b0, ovf_v[0]}, {31'b0, m_ovf});
        drain(0, "ovf");
        pulse_clear(0);
        check("ovf_cleared", flags(0), 32'd0);
        m_ovf = 1'b0;

        // mode 1: CS raised after 5 bits, then a complete frame
        cs_low(2);
        send_bits(2, 5, rnd(2));
        cs_high(2);
        wait_clk(2);
        check("m1_abort", flags(2), 32'd1);
        check("m1_no_push", {29'b0, cnt_v[2]}, 32'd0);
        cs_low(2);
        send_word(2, 32'h3C);
        model_push(32'h3C);
        w = rnd(2);
        send_word(2, w);
        model_push(w);
        cs_high(2);
        wait_clk(6);
        drain(2, "m1");
        pulse_clear(2);
        check("m1_cleared", flags(2), 32'd0);

        // stall timeout: 3 bits then 60 idle clocks, frame resumes under same CS
        cs_low(0);
        send_bits(0, 3, rnd(0));
        wait_clk(60);
        check("tmo_flag", flags(0), 32'd2);
        check("tmo_count", {29'b0, cnt_v[0]}, 32'd0);
        check("tmo_busy", {31'b0, busy_v[0]}, 32'd1);
        send_word(0, 32'hC3);
        model_push(32'hC3);
        cs_high(0);
        wait_clk(6);
        check("tmo_no_abort", flags(0), 32'd2);
        drain(0, "tmo");
        pulse_clear(0);

        // asynchronous reset mid-frame with two frames queued
        cs_low(0);
        for (int i = 0; i < 2; i++) send_word(0, rnd(0));
        send_bits(0, 4, rnd(0));
        wait_clk(6);
        check("prerst_count", {29'b0, cnt_v[0]}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("rst_count", {29'b0, cnt_v[0]}, 32'd0);
        check("rst_valid", {31'b0, val_v[0]}, 32'd0);
        check("rst_data", head(0), 32'd0);
        check("rst_busy", {31'b0, busy_v[0]}, 32'd0);
        check("rst_flags", flags(0), 32'd0);
        csn_v[0] = 1'b1;
        copi_v[0] = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        exp_q.delete();
        wait_clk(4);
        cs_low(0);
        send_word(0, 32'h5A);
        model_push(32'h5A);
        cs_high(0);
        wait_clk(6);
        check("post_rst_head", head(0), 32'h5A);
        drain(0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // overall time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
